// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings, byte width and default sizing for the uart byte FIFO.
package uart_pkg;
    localparam int BYTE_W              = 8;
    localparam int DEF_DEPTH_LOG2      = 4;
    localparam int DEF_TX_ACK_TIMEOUT  = 64;
    typedef enum logic {R_IDLE, R_ACK} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_RETRY, T_BUSY} tx_state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: rx drain and tx replay handshake between the uart core (master) and the byte FIFO (slave).
interface uart_rx_fifo_if;
    import uart_pkg::*;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;
    logic              rx_ready_clear;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_en;
    logic              tx_busy;
    modport master (output rx_data, rx_ready, tx_busy, input rx_ready_clear, tx_data, tx_en);
    modport slave  (input rx_data, rx_ready, tx_busy, output rx_ready_clear, tx_data, tx_en);
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: byte register array, synchronous write, combinational read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  sys_clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DEPTH_LOG2-1:0] raddr,
    input  logic [BYTE_W-1:0]     wdata,
    output logic [BYTE_W-1:0]     rdata
);
    logic [BYTE_W-1:0] mem [1<<DEPTH_LOG2];
    always_ff @(posedge sys_clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO draining uart rx and replaying to uart tx with ack timeout and retry.
// Optional UART_FIFO_DROP_CNT_EN adds a saturating drop_cnt output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
    parameter int TX_ACK_TIMEOUT = DEF_TX_ACK_TIMEOUT
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    uart_rx_fifo_if.slave       uart,
    output logic [DEPTH_LOG2:0] level,
    output logic                full,
    output logic                empty,
`ifdef UART_FIFO_DROP_CNT_EN
    output logic [7:0]          drop_cnt,
`endif
    output logic                overflow
);
    localparam int LW = DEPTH_LOG2 + 1;
    localparam int TW = $clog2(TX_ACK_TIMEOUT);
    rx_state_t               rx_state, rx_next;
    tx_state_t               tx_state, tx_next;
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [BYTE_W-1:0]       head, tx_data_n;
    logic [TW-1:0]           timer, timer_n;
    logic                    capture, wr, pop, tx_en_n;

    assign uart.rx_ready_clear = rx_state == R_ACK;
    assign capture = rx_state == R_IDLE && uart.rx_ready && !uart.rx_ready_clear;
    assign pop     = tx_state == T_IDLE && !empty && !uart.tx_busy;
    // a pop on the same edge frees the head slot, so a full FIFO still accepts the byte
    assign wr      = capture && (!full || pop);
    assign full    = level == LW'(1 << DEPTH_LOG2);
    assign empty   = level == '0;

    uart_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .sys_clk(sys_clk), .we(wr), .waddr(wr_ptr), .raddr(rd_ptr), .wdata(uart.rx_data), .rdata(head)
    );

    always_comb begin
        rx_next = capture ? R_ACK : (rx_state == R_ACK && !uart.rx_ready) ? R_IDLE : rx_state;
    end

    always_comb begin
        tx_next   = tx_state;
        tx_en_n   = uart.tx_en;
        tx_data_n = uart.tx_data;
        timer_n   = timer;
        case (tx_state)
            T_IDLE:  if (pop) begin
                         tx_next   = T_REQ;
                         tx_en_n   = 1'b1;
                         tx_data_n = head;
                         timer_n   = '0;
                     end
            T_REQ:   if (uart.tx_busy) begin
                         tx_next = T_BUSY;
                         tx_en_n = 1'b0;
                     end else if (timer == TW'(TX_ACK_TIMEOUT - 1)) begin
                         tx_next = T_RETRY;
                         tx_en_n = 1'b0;
                     end else timer_n = timer + 1'b1;
            T_RETRY: begin
                         tx_next = T_REQ;
                         tx_en_n = 1'b1;
                         timer_n = '0;
                     end
            T_BUSY:  if (!uart.tx_busy) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            rx_state     <= R_IDLE;
            tx_state     <= T_IDLE;
            uart.tx_en   <= 1'b0;
            uart.tx_data <= '0;
            timer        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
        end else begin
            rx_state     <= rx_next;
            tx_state     <= tx_next;
            uart.tx_en   <= tx_en_n;
            uart.tx_data <= tx_data_n;
            timer        <= timer_n;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level        <= level + {{DEPTH_LOG2{1'b0}}, wr} - {{DEPTH_LOG2{1'b0}}, pop};
            overflow     <= overflow | (capture && !wr);
        end

`ifdef UART_FIFO_DROP_CNT_EN
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) drop_cnt <= '0;
        else if (capture && !wr && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vectors plus corner-case sequences against a small uart tx model.
module tb_uart_rx_fifo;
    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [4:0] level;
    logic       full, empty, overflow;
`ifdef UART_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif
    uart_rx_fifo_if bus();

    uart_rx_fifo #(.DEPTH_LOG2(4), .TX_ACK_TIMEOUT(64)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .uart(bus), .level(level), .full(full), .empty(empty),
`ifdef UART_FIFO_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] data;
        int         blen;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[5];

    int         total = 0;
    int         bad   = 0;
    bit         model_on = 0;
    bit         busy_force = 0;
    int         busy_len = 10;
    int         en_rises = 0;
    logic [7:0] got[$];

    // uart tx model: when enabled, accepts tx_en, raises tx_busy 2 cycles later for busy_len cycles
    initial begin
        int   bcnt;
        int   dly;
        logic prev_en;
        bcnt = 0; dly = 0; prev_en = 1'b0; bus.tx_busy = 1'b0;
        forever begin
            @(posedge sys_clk); #2;
            if (bus.tx_en && !prev_en) en_rises++;
            prev_en = bus.tx_en;
            if (!model_on) begin
                bus.tx_busy = busy_force; bcnt = 0; dly = 0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) bus.tx_busy = 1'b0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin bus.tx_busy = 1'b1; bcnt = busy_len; end
            end else begin
                bus.tx_busy = 1'b0;
                if (bus.tx_en) begin got.push_back(bus.tx_data); dly = 2; end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge sys_clk); #1;
    endtask

    task automatic do_reset;
        model_on = 0;
        rst_n = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.rx_data = b;
        bus.rx_ready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.rx_ready_clear && n < 50);
        if (!bus.rx_ready_clear) chk("rx_ack_timeout", 32'(bus.rx_ready_clear), 1);
        bus.rx_ready = 1'b0;
        n = 0;
        do begin step(); n++; end while (bus.rx_ready_clear && n < 50);
        if (bus.rx_ready_clear) chk("rx_clear_stuck", 32'(bus.rx_ready_clear), 0);
    endtask

    task automatic wait_got(input int n);
        int k;
        k = 0;
        while (!(got.size() >= n && !bus.tx_en && !bus.tx_busy) && k < 3000) begin step(); k++; end
        if (k >= 3000) chk("drain_timeout", 32'(got.size()), 32'(n));
        repeat (3) step();
    endtask

    initial begin
        int b0;
        int r0;
        int cnt;
        vecs[0] = '{8'h41, 10, 8'h41};
        vecs[1] = '{8'h00, 1,  8'h00};
        vecs[2] = '{8'hFF, 3,  8'hFF};
        vecs[3] = '{8'hA5, 5,  8'hA5};
        vecs[4] = '{8'h5A, 2,  8'h5A};
        rst_n = 1'b0;
        bus.rx_data = '0;
        bus.rx_ready = 1'b0;
        repeat (3) step();
        chk("rst_clear",    32'(bus.rx_ready_clear), 0);
        chk("rst_tx_en",    32'(bus.tx_en), 0);
        chk("rst_tx_data",  32'(bus.tx_data), 0);
        chk("rst_level",    32'(level), 0);
        chk("rst_empty",    32'(empty), 1);
        chk("rst_full",     32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        step();

        // single byte latency: written next edge, tx_en one edge later
        busy_len = 10; model_on = 1; b0 = got.size(); r0 = en_rises;
        bus.rx_data = 8'h41; bus.rx_ready = 1'b1;
        step();
        chk("lat_level1", 32'(level), 1);
        chk("lat_clear1", 32'(bus.rx_ready_clear), 1);
        chk("lat_en0",    32'(bus.tx_en), 0);
        bus.rx_ready = 1'b0;
        step();
        chk("lat_en1",    32'(bus.tx_en), 1);
        chk("lat_data",   32'(bus.tx_data), 'h41);
        chk("lat_level0", 32'(level), 0);
        wait_got(b0 + 1);
        chk("lat_got",    32'(got[b0]), 'h41);
        chk("lat_pulses", 32'(en_rises - r0), 1);

        for (int i = 0; i < 5; i++) begin
            busy_len = vecs[i].blen; b0 = got.size(); r0 = en_rises;
            send_byte(vecs[i].data);
            wait_got(b0 + 1);
            chk("vec_data",   32'(got[b0]), 32'(vecs[i].exp));
            chk("vec_pulses", 32'(en_rises - r0), 1);
            chk("vec_level",  32'(level), 0);
            chk("vec_empty",  32'(empty), 1);
        end

        // rx_ready held long: one write, clear released only after rx_ready falls
        model_on = 0; busy_force = 1; step();
        bus.rx_data = 8'h33; bus.rx_ready = 1'b1;
        repeat (20) step();
        chk("hold_level", 32'(level), 1);
        chk("hold_clear", 32'(bus.rx_ready_clear), 1);
        bus.rx_ready = 1'b0;
        step();
        chk("hold_clear_fall", 32'(bus.rx_ready_clear), 0);
        chk("hold_level2", 32'(level), 1);
        b0 = got.size(); busy_len = 2; model_on = 1;
        wait_got(b0 + 1);
        chk("hold_got",   32'(got[b0]), 'h33);
        chk("hold_count", 32'(got.size() - b0), 1);

        // overflow: 17 bytes into a blocked FIFO
        do_reset(); busy_force = 1; step();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("ovf_full",   32'(full), 1);
        chk("ovf_level",  32'(level), 16);
        chk("ovf_flag0",  32'(overflow), 0);
        send_byte(8'h10);
        chk("ovf_flag1",  32'(overflow), 1);
        chk("ovf_level2", 32'(level), 16);
        b0 = got.size(); busy_len = 1; model_on = 1;
        wait_got(b0 + 16);
        for (int i = 0; i < 16; i++) chk("ovf_order", 32'(got[b0 + i]), 32'(i));
        chk("ovf_count", 32'(got.size() - b0), 16);
        chk("ovf_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);

        // ack timeout and retry
        do_reset(); busy_force = 0; step();
        r0 = en_rises;
        bus.rx_data = 8'h77; bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        cnt = 0;
        while (!bus.tx_en && cnt < 10) begin step(); cnt++; end
        cnt = 0;
        while (bus.tx_en && cnt < 200) begin step(); cnt++; end
        chk("to_high_len", 32'(cnt), 64);
        cnt = 0;
        while (!bus.tx_en && cnt < 10) begin step(); cnt++; end
        chk("to_low_len",  32'(cnt), 1);
        chk("to_retry_data", 32'(bus.tx_data), 'h77);
        chk("to_level",    32'(level), 0);
        b0 = got.size(); busy_len = 3; model_on = 1;
        wait_got(b0 + 1);
        chk("to_got",      32'(got[b0]), 'h77);
        chk("to_rises",    32'(en_rises - r0), 2);

        // full FIFO with write and pop on the same edge
        do_reset(); busy_force = 1; step();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i));
        chk("wp_full_before", 32'(full), 1);
        bus.rx_data = 8'hEE; bus.rx_ready = 1'b1; busy_force = 0;
        step();
        chk("wp_level",    32'(level), 16);
        chk("wp_overflow", 32'(overflow), 0);
        chk("wp_tx_en",    32'(bus.tx_en), 1);
        chk("wp_tx_data",  32'(bus.tx_data), 'h80);
        bus.rx_ready = 1'b0;
        step();
        b0 = got.size(); busy_len = 1; model_on = 1;
        wait_got(b0 + 17);
        for (int i = 0; i < 16; i++) chk("wp_order", 32'(got[b0 + i]), 32'('h80 + i));
        chk("wp_last", 32'(got[b0 + 16]), 'hEE);

        // asynchronous reset while in T_BUSY with 5 bytes stored
        do_reset(); busy_force = 0; step();
        send_byte(8'h01);
        busy_force = 1;
        repeat (2) step();
        for (int i = 2; i < 7; i++) send_byte(8'(i));
        chk("rb_level5", 32'(level), 5);
        chk("rb_tx_en",  32'(bus.tx_en), 0);
        bus.rx_data = 8'h99; bus.rx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rb_clear",    32'(bus.rx_ready_clear), 0);
        chk("rb_tx_en0",   32'(bus.tx_en), 0);
        chk("rb_tx_data",  32'(bus.tx_data), 0);
        chk("rb_level",    32'(level), 0);
        chk("rb_empty",    32'(empty), 1);
        chk("rb_full",     32'(full), 0);
        chk("rb_overflow", 32'(overflow), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rb_recapture", 32'(level), 1);
        bus.rx_ready = 1'b0;
        step();
        b0 = got.size(); busy_len = 2; model_on = 1;
        wait_got(b0 + 1);
        chk("rb_got", 32'(got[b0]), 'h99);

`ifdef UART_FIFO_DROP_CNT_EN
        do_reset(); busy_force = 1; step();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("dc_zero", 32'(drop_cnt), 0);
        for (int i = 0; i < 300; i++) send_byte(8'hC3);
        chk("dc_sat",   32'(drop_cnt), 255);
        chk("dc_level", 32'(level), 16);
        chk("dc_ovf",   32'(overflow), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
